// File: rtl/ppu_vram_oam_port_if.sv
// CPU MMIO, PPU fetch and OAM DMA source signals shared between the memory responder and its clients.
// The responder connects through the slave modport.
interface ppu_vram_oam_port_if;
  logic [15:0] ADDR;
  logic        WR;
  logic        RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  MMIO_DATA_in;
  logic [1:0]  PPU_MODE;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_DATA_in;
  logic        DMA_RD;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DATA;
  logic        DMA_ACTIVE;

  modport slave (
    input  ADDR, WR, RD, MMIO_DATA_out, PPU_MODE, PPU_RD, PPU_ADDR, DMA_DATA,
    output MMIO_DATA_in, PPU_DATA_in, DMA_RD, DMA_ADDR, DMA_ACTIVE
  );

  modport master (
    output ADDR, WR, RD, MMIO_DATA_out, PPU_MODE, PPU_RD, PPU_ADDR, DMA_DATA,
    input  MMIO_DATA_in, PPU_DATA_in, DMA_RD, DMA_ADDR, DMA_ACTIVE
  );
endinterface

// File: rtl/ppu_vram_oam_port.sv
// VRAM/OAM owner: serves PPU fetches every cycle, arbitrates CPU MMIO by PPU mode,
// and runs the OAM DMA engine started by a write to 0xFF46.
module ppu_vram_oam_port #(
  parameter int VRAM_DEPTH = 8192,
  parameter int OAM_DEPTH  = 160,
  parameter int DMA_LEN    = 160
) (
  input logic              clk,
  input logic              rst_n,
  ppu_vram_oam_port_if.slave bus
);
  localparam int          VAW       = $clog2(VRAM_DEPTH);
  localparam int          OAW       = $clog2(OAM_DEPTH);
  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] DMA_REG   = 16'hFF46;
  localparam logic [7:0]  LAST_IDX  = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } dma_state_t;

  logic [7:0] r_vram [VRAM_DEPTH];
  logic [7:0] r_oam  [OAM_DEPTH];

  dma_state_t  r_state, w_state_n;
  logic [15:0] r_src, w_src_n;
  logic [7:0]  r_idx, w_idx_n;
  logic [15:0] r_dma_addr, w_dma_addr_n;
  logic        r_dma_rd, r_dma_active;
  logic [7:0]  r_ppu_data, r_mmio_data;

  logic [15:0]    w_cpu_vram_diff, w_cpu_oam_diff, w_ppu_vram_diff, w_ppu_oam_diff;
  logic [VAW-1:0] w_cpu_vram_off, w_ppu_vram_off;
  logic [OAW-1:0] w_cpu_oam_off, w_ppu_oam_off;
  logic           w_cpu_in_vram, w_cpu_in_oam, w_ppu_in_vram, w_ppu_in_oam;
  logic           w_vram_lock, w_oam_lock, w_cpu_vram_ok, w_cpu_oam_ok;
  logic           w_dma_trig, w_dma_we;
  logic [7:0]     w_dma_slot;
  logic           w_oam_we;
  logic [OAW-1:0] w_oam_waddr;
  logic [7:0]     w_oam_wdata;
  logic           w_unused_ppu_rd;

  // Base-relative unsigned compare covers both range bounds at once.
  assign w_cpu_vram_diff = bus.ADDR - VRAM_BASE;
  assign w_cpu_oam_diff  = bus.ADDR - OAM_BASE;
  assign w_ppu_vram_diff = bus.PPU_ADDR - VRAM_BASE;
  assign w_ppu_oam_diff  = bus.PPU_ADDR - OAM_BASE;
  assign w_cpu_in_vram   = (w_cpu_vram_diff < 16'(VRAM_DEPTH));
  assign w_cpu_in_oam    = (w_cpu_oam_diff < 16'(OAM_DEPTH));
  assign w_ppu_in_vram   = (w_ppu_vram_diff < 16'(VRAM_DEPTH));
  assign w_ppu_in_oam    = (w_ppu_oam_diff < 16'(OAM_DEPTH));
  assign w_cpu_vram_off  = w_cpu_vram_diff[VAW-1:0];
  assign w_cpu_oam_off   = w_cpu_oam_diff[OAW-1:0];
  assign w_ppu_vram_off  = w_ppu_vram_diff[VAW-1:0];
  assign w_ppu_oam_off   = w_ppu_oam_diff[OAW-1:0];

  assign w_vram_lock     = (bus.PPU_MODE == 2'd3);
  assign w_oam_lock      = bus.PPU_MODE[1] | r_dma_active;
  assign w_cpu_vram_ok   = w_cpu_in_vram & ~w_vram_lock;
  assign w_cpu_oam_ok    = w_cpu_in_oam & ~w_oam_lock;
  assign w_dma_trig      = bus.WR & (bus.ADDR == DMA_REG);
  assign w_unused_ppu_rd = bus.PPU_RD;

  // DMA next-state, index/source update and OAM slot being retired this cycle.
  always_comb begin
    w_state_n  = r_state;
    w_src_n    = r_src;
    w_idx_n    = r_idx;
    w_dma_we   = 1'b0;
    w_dma_slot = r_idx - 8'd1;
    case (r_state)
      S_RUN: begin
        w_dma_we = (r_idx != 8'd0);
        w_idx_n  = r_idx + 8'd1;
        if (r_idx == LAST_IDX) w_state_n = S_DRAIN;
        else                   w_state_n = S_RUN;
      end
      S_DRAIN: begin
        w_dma_we   = 1'b1;
        w_dma_slot = LAST_IDX;
        w_idx_n    = 8'd0;
        w_state_n  = S_IDLE;
      end
      S_IDLE:  w_state_n = S_IDLE;
      default: begin
        w_state_n = S_IDLE;
        w_idx_n   = 8'd0;
      end
    endcase
    // A retrigger still retires the in-flight byte above, then restarts.
    if (w_dma_trig) begin
      w_state_n = S_RUN;
      w_src_n   = {bus.MMIO_DATA_out, 8'h00};
      w_idx_n   = 8'd0;
    end else begin
      w_src_n = w_src_n;
    end
    if (w_state_n == S_RUN) w_dma_addr_n = w_src_n + {8'h00, w_idx_n};
    else                    w_dma_addr_n = r_dma_addr;
  end

  // Single OAM write port: DMA wins; the CPU is locked out whenever DMA runs.
  always_comb begin
    w_oam_we    = 1'b0;
    w_oam_waddr = w_cpu_oam_off;
    w_oam_wdata = bus.MMIO_DATA_out;
    if (w_dma_we) begin
      w_oam_we    = 1'b1;
      w_oam_waddr = OAW'(w_dma_slot);
      w_oam_wdata = bus.DMA_DATA;
    end else if (bus.WR && w_cpu_oam_ok) begin
      w_oam_we = 1'b1;
    end else begin
      w_oam_we = 1'b0;
    end
  end

  // DMA state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_src        <= 16'h0000;
      r_idx        <= 8'd0;
      r_dma_addr   <= 16'h0000;
      r_dma_rd     <= 1'b0;
      r_dma_active <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_src        <= w_src_n;
      r_idx        <= w_idx_n;
      r_dma_addr   <= w_dma_addr_n;
      r_dma_rd     <= (w_state_n == S_RUN);
      r_dma_active <= (w_state_n != S_IDLE);
    end
  end

  // Memory arrays are not reset.
  always_ff @(posedge clk) begin
    if (bus.WR && w_cpu_vram_ok) r_vram[w_cpu_vram_off] <= bus.MMIO_DATA_out;
    if (w_oam_we)                r_oam[w_oam_waddr]     <= w_oam_wdata;
  end

  // PPU fetch and CPU read data; reads see the pre-write array contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ppu_data  <= 8'hFF;
      r_mmio_data <= 8'hFF;
    end else begin
      if (w_ppu_in_vram)                     r_ppu_data <= r_vram[w_ppu_vram_off];
      else if (w_ppu_in_oam && !r_dma_active) r_ppu_data <= r_oam[w_ppu_oam_off];
      else                                   r_ppu_data <= 8'hFF;
      if (bus.RD) begin
        if (w_cpu_vram_ok)     r_mmio_data <= r_vram[w_cpu_vram_off];
        else if (w_cpu_oam_ok) r_mmio_data <= r_oam[w_cpu_oam_off];
        else                   r_mmio_data <= 8'hFF;
      end
    end
  end

  assign bus.PPU_DATA_in  = r_ppu_data;
  assign bus.MMIO_DATA_in = r_mmio_data;
  assign bus.DMA_RD       = r_dma_rd;
  assign bus.DMA_ADDR     = r_dma_addr;
  assign bus.DMA_ACTIVE   = r_dma_active;
endmodule

// File: tb/tb_ppu_vram_oam_port.sv
// Self-checking bench for ppu_vram_oam_port: directed lock/DMA scenarios plus
// randomized CPU/PPU traffic against an array-based memory model.
module tb_ppu_vram_oam_port;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ppu_vram_oam_port_if bus();

  ppu_vram_oam_port #(.VRAM_DEPTH(8192), .OAM_DEPTH(160), .DMA_LEN(160)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // DMA source memory: data for an address appears the cycle after it is presented.
  logic [15:0] src_q;
  function automatic logic [7:0] src_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h64;
  endfunction
  always @(posedge clk) src_q <= bus.DMA_ADDR;
  assign bus.DMA_DATA = src_fn(src_q);

  logic [7:0] vram_m [8192];
  bit         vram_k [8192];
  logic [7:0] oam_m  [160];
  bit         oam_k  [160];
  logic [7:0] exp_mmio;
  bit         exp_mmio_k;
  int checks = 0;
  int failures = 0;

  function automatic bit in_vram(input logic [15:0] a);
    return (a >= 16'h8000) && (a <= 16'h9FFF);
  endfunction
  function automatic bit in_oam(input logic [15:0] a);
    return (a >= 16'hFE00) && (a <= 16'hFE9F);
  endfunction
  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 16'h8000 + 16'($urandom_range(0, 31));
      2:       return 16'h9FF0 + 16'($urandom_range(0, 31));
      3:       return 16'hFE00 + 16'($urandom_range(0, 159));
      4:       return 16'hFE90 + 16'($urandom_range(0, 31));
      default: return 16'h7FF0 + 16'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d);
    bus.WR = wr;
    bus.RD = rd;
    bus.ADDR = a;
    bus.MMIO_DATA_out = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    bus.PPU_MODE = 2'd0;
    bus.PPU_RD = 1'b1;
    bus.PPU_ADDR = 16'h0000;
    repeat (2) tick();
    checks++; if (bus.PPU_DATA_in !== 8'hFF) begin failures++; $display("FAIL reset_ppu_data got=%h exp=ff", bus.PPU_DATA_in); end
    checks++; if (bus.MMIO_DATA_in !== 8'hFF) begin failures++; $display("FAIL reset_mmio_data got=%h exp=ff", bus.MMIO_DATA_in); end
    checks++; if (bus.DMA_ACTIVE !== 1'b0) begin failures++; $display("FAIL reset_dma_active got=%b exp=0", bus.DMA_ACTIVE); end
    checks++; if (bus.DMA_RD !== 1'b0) begin failures++; $display("FAIL reset_dma_rd got=%b exp=0", bus.DMA_RD); end
    checks++; if (bus.DMA_ADDR !== 16'h0000) begin failures++; $display("FAIL reset_dma_addr got=%h exp=0000", bus.DMA_ADDR); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.PPU_DATA_in !== 8'hFF) begin failures++; $display("FAIL post_reset_ppu got=%h exp=ff", bus.PPU_DATA_in); end
    checks++; if (bus.DMA_ACTIVE !== 1'b0) begin failures++; $display("FAIL post_reset_active got=%b exp=0", bus.DMA_ACTIVE); end
  endtask

  task automatic test_vram_lock();
    bus.PPU_MODE = 2'd0;
    cpu(1'b1, 1'b0, 16'h8010, 8'h3C); tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00); bus.PPU_ADDR = 16'h8010; tick();
    checks++; if (bus.PPU_DATA_in !== 8'h3C) begin failures++; $display("FAIL vram_write_fetch got=%h exp=3c", bus.PPU_DATA_in); end
    bus.PPU_MODE = 2'd3;
    cpu(1'b1, 1'b0, 16'h8010, 8'h55); tick();
    cpu(1'b0, 1'b1, 16'h8010, 8'h00); tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    checks++; if (bus.MMIO_DATA_in !== 8'hFF) begin failures++; $display("FAIL vram_locked_read got=%h exp=ff", bus.MMIO_DATA_in); end
    checks++; if (bus.PPU_DATA_in !== 8'h3C) begin failures++; $display("FAIL vram_locked_fetch got=%h exp=3c", bus.PPU_DATA_in); end
    bus.PPU_MODE = 2'd0;
    cpu(1'b1, 1'b0, 16'h9FFF, 8'h9E); tick();
    cpu(1'b0, 1'b1, 16'h9FFF, 8'h00); bus.PPU_ADDR = 16'h9FFF; tick();
    checks++; if (bus.PPU_DATA_in !== 8'h9E) begin failures++; $display("FAIL vram_top_fetch got=%h exp=9e", bus.PPU_DATA_in); end
    checks++; if (bus.MMIO_DATA_in !== 8'h9E) begin failures++; $display("FAIL vram_top_read got=%h exp=9e", bus.MMIO_DATA_in); end
    cpu(1'b0, 1'b0, 16'h0000, 8'h00); bus.PPU_ADDR = 16'hA000; tick();
    checks++; if (bus.PPU_DATA_in !== 8'hFF) begin failures++; $display("FAIL vram_above_fetch got=%h exp=ff", bus.PPU_DATA_in); end
    vram_m[16'h0010] = 8'h3C; vram_k[16'h0010] = 1'b1;
    vram_m[16'h1FFF] = 8'h9E; vram_k[16'h1FFF] = 1'b1;
  endtask

  task automatic test_oam_lock();
    bus.PPU_MODE = 2'd0;
    cpu(1'b1, 1'b0, 16'hFE04, 8'h77); tick();
    bus.PPU_MODE = 2'd2;
    cpu(1'b1, 1'b0, 16'hFE04, 8'h12); tick();
    bus.PPU_MODE = 2'd1;
    cpu(1'b0, 1'b1, 16'hFE04, 8'h00); tick();
    checks++; if (bus.MMIO_DATA_in !== 8'h77) begin failures++; $display("FAIL oam_scan_write_dropped got=%h exp=77", bus.MMIO_DATA_in); end
    cpu(1'b1, 1'b0, 16'hFE04, 8'h12); tick();
    cpu(1'b0, 1'b1, 16'hFE04, 8'h00); tick();
    checks++; if (bus.MMIO_DATA_in !== 8'h12) begin failures++; $display("FAIL oam_vblank_write got=%h exp=12", bus.MMIO_DATA_in); end
    cpu(1'b0, 1'b1, 16'hFEA0, 8'h00); tick();
    checks++; if (bus.MMIO_DATA_in !== 8'hFF) begin failures++; $display("FAIL oam_above_read got=%h exp=ff", bus.MMIO_DATA_in); end
    cpu(1'b1, 1'b0, 16'hFE9F, 8'h9F); tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00); bus.PPU_ADDR = 16'hFE9F; tick();
    checks++; if (bus.PPU_DATA_in !== 8'h9F) begin failures++; $display("FAIL oam_top_fetch got=%h exp=9f", bus.PPU_DATA_in); end
    checks++; if (bus.MMIO_DATA_in !== 8'hFF) begin failures++; $display("FAIL mmio_hold got=%h exp=ff", bus.MMIO_DATA_in); end
    bus.PPU_MODE = 2'd3;
    cpu(1'b0, 1'b1, 16'hFE9F, 8'h00); tick();
    checks++; if (bus.MMIO_DATA_in !== 8'hFF) begin failures++; $display("FAIL oam_draw_read got=%h exp=ff", bus.MMIO_DATA_in); end
    checks++; if (bus.PPU_DATA_in !== 8'h9F) begin failures++; $display("FAIL oam_draw_fetch got=%h exp=9f", bus.PPU_DATA_in); end
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    bus.PPU_MODE = 2'd0;
    oam_m[4] = 8'h12; oam_k[4] = 1'b1;
    oam_m[159] = 8'h9F; oam_k[159] = 1'b1;
  endtask

  task automatic test_dma_copy();
    int c;
    bus.PPU_MODE = 2'd0;
    bus.PPU_ADDR = 16'hFE00;
    cpu(1'b1, 1'b0, 16'hFF46, 8'hC1); tick();
    cpu(1'b0, 1'b0, 16'hFE10, 8'h00);
    for (c = 1; c < 400; c++) begin
      if (bus.DMA_ACTIVE !== 1'b1) break;
      if (c <= 160) begin
        checks++; if (bus.DMA_RD !== 1'b1) begin failures++; $display("FAIL dma_rd c=%0d got=%b exp=1", c, bus.DMA_RD); end
        checks++; if (bus.DMA_ADDR !== 16'hC100 + 16'(c - 1)) begin failures++; $display("FAIL dma_addr c=%0d got=%h exp=%h", c, bus.DMA_ADDR, 16'hC100 + 16'(c - 1)); end
      end else begin
        checks++; if (bus.DMA_RD !== 1'b0) begin failures++; $display("FAIL dma_drain_rd c=%0d got=%b exp=0", c, bus.DMA_RD); end
      end
      if (c >= 2) begin
        checks++; if (bus.PPU_DATA_in !== 8'hFF) begin failures++; $display("FAIL dma_ppu_oam_fetch c=%0d got=%h exp=ff", c, bus.PPU_DATA_in); end
      end
      if (c == 21) begin
        checks++; if (bus.MMIO_DATA_in !== 8'hFF) begin failures++; $display("FAIL dma_cpu_oam_read got=%h exp=ff", bus.MMIO_DATA_in); end
      end
      bus.RD = (c == 20);
      bus.WR = (c == 30);
      tick();
    end
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    checks++; if (c - 1 != 161) begin failures++; $display("FAIL dma_active_cycles got=%0d exp=161", c - 1); end
    for (int k = 0; k < 160; k++) begin
      oam_m[k] = 8'(k) ^ 8'hA5;
      oam_k[k] = 1'b1;
    end
  endtask

  task automatic test_dma_restart();
    int c;
    bus.PPU_MODE = 2'd0;
    cpu(1'b1, 1'b0, 16'hFF46, 8'hC1); tick();
    cpu(1'b0, 1'b0, 16'hFF46, 8'hD0);
    for (c = 1; c < 400; c++) begin
      if (bus.DMA_ACTIVE !== 1'b1) break;
      if (c == 50) begin
        checks++; if (bus.DMA_ADDR !== 16'hC131) begin failures++; $display("FAIL restart_pre_addr got=%h exp=c131", bus.DMA_ADDR); end
      end
      if (c == 51) begin
        checks++; if (bus.DMA_ADDR !== 16'hD000) begin failures++; $display("FAIL restart_jump_addr got=%h exp=d000", bus.DMA_ADDR); end
      end
      if (c == 52) begin
        checks++; if (bus.DMA_ADDR !== 16'hD001) begin failures++; $display("FAIL restart_next_addr got=%h exp=d001", bus.DMA_ADDR); end
      end
      bus.WR = (c == 50);
      tick();
    end
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    checks++; if (c != 212) begin failures++; $display("FAIL restart_end_cycle got=%0d exp=212", c); end
    for (int k = 0; k < 160; k++) oam_m[k] = 8'(k) ^ 8'hB4;
  endtask

  task automatic test_reset_mid_dma();
    bus.PPU_MODE = 2'd0;
    cpu(1'b1, 1'b0, 16'hFF46, 8'hC1); tick();
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    for (int c = 1; c < 81; c++) tick();
    checks++; if (bus.DMA_ACTIVE !== 1'b1) begin failures++; $display("FAIL mid_dma_active got=%b exp=1", bus.DMA_ACTIVE); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.DMA_ACTIVE !== 1'b0) begin failures++; $display("FAIL abort_active got=%b exp=0", bus.DMA_ACTIVE); end
    checks++; if (bus.DMA_RD !== 1'b0) begin failures++; $display("FAIL abort_rd got=%b exp=0", bus.DMA_RD); end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.DMA_ACTIVE !== 1'b0) begin failures++; $display("FAIL after_abort_active got=%b exp=0", bus.DMA_ACTIVE); end
    checks++; if (bus.MMIO_DATA_in !== 8'hFF) begin failures++; $display("FAIL after_abort_mmio got=%h exp=ff", bus.MMIO_DATA_in); end
    for (int k = 0; k <= 78; k++) oam_m[k] = 8'(k) ^ 8'hA5;
  endtask

  task automatic test_oam_readback();
    bus.PPU_MODE = 2'd0;
    for (int k = 0; k < 160; k++) begin
      cpu(1'b0, 1'b1, 16'hFE00 + 16'(k), 8'h00);
      tick();
      checks++; if (bus.MMIO_DATA_in !== oam_m[k]) begin failures++; $display("FAIL oam_readback k=%0d got=%h exp=%h", k, bus.MMIO_DATA_in, oam_m[k]); end
    end
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    exp_mmio = oam_m[159];
    exp_mmio_k = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] a, p;
    logic [7:0]  d, ep;
    logic [1:0]  m;
    bit          wr, rd, ep_k;
    int          vi, oi;
    for (int i = 0; i < 600; i++) begin
      m  = 2'($urandom_range(0, 3));
      a  = pick_addr();
      p  = pick_addr();
      d  = 8'($urandom_range(0, 255));
      wr = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 1) == 1);
      ep = 8'hFF;
      ep_k = 1'b1;
      if (in_vram(p)) begin
        vi = int'(p) - 32'h8000; ep = vram_m[vi]; ep_k = vram_k[vi];
      end else if (in_oam(p)) begin
        oi = int'(p) - 32'hFE00; ep = oam_m[oi]; ep_k = oam_k[oi];
      end
      vi = int'(a) - 32'h8000;
      oi = int'(a) - 32'hFE00;
      if (rd) begin
        exp_mmio = 8'hFF;
        exp_mmio_k = 1'b1;
        if (in_vram(a) && m != 2'd3) begin
          exp_mmio = vram_m[vi]; exp_mmio_k = vram_k[vi];
        end else if (in_oam(a) && m < 2'd2) begin
          exp_mmio = oam_m[oi]; exp_mmio_k = oam_k[oi];
        end
      end
      if (wr && in_vram(a) && m != 2'd3) begin
        vram_m[vi] = d; vram_k[vi] = 1'b1;
      end else if (wr && in_oam(a) && m < 2'd2) begin
        oam_m[oi] = d; oam_k[oi] = 1'b1;
      end
      bus.PPU_MODE = m;
      bus.PPU_ADDR = p;
      cpu(wr, rd, a, d);
      tick();
      if (ep_k) begin
        checks++; if (bus.PPU_DATA_in !== ep) begin failures++; $display("FAIL rand_fetch i=%0d addr=%h got=%h exp=%h", i, p, bus.PPU_DATA_in, ep); end
      end
      if (exp_mmio_k) begin
        checks++; if (bus.MMIO_DATA_in !== exp_mmio) begin failures++; $display("FAIL rand_mmio i=%0d addr=%h got=%h exp=%h", i, a, bus.MMIO_DATA_in, exp_mmio); end
      end
      checks++; if (bus.DMA_ACTIVE !== 1'b0) begin failures++; $display("FAIL rand_dma_idle i=%0d got=%b exp=0", i, bus.DMA_ACTIVE); end
    end
    cpu(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    exp_mmio = 8'hFF;
    exp_mmio_k = 1'b1;
    test_reset();
    test_vram_lock();
    test_oam_lock();
    test_dma_copy();
    test_oam_readback();
    test_dma_restart();
    test_oam_readback();
    test_reset_mid_dma();
    test_oam_readback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
